up_bus_arbiter: RTL and testbench

Two-master arbiter for the internal up register bus (up_wreq/up_waddr/up_wdata/up_wack and up_rreq/up_raddr/up_rdata/up_rack). It sits between the AXI bridge, as master 0, and a local configuration sequencer, as master 1, on one side, and the OR-combined TPL regmap slaves on the other. Read and write channels are arbitrated independently with round-robin fairness. A per-channel timeout guarantees every accepted request is acknowledged.

---
 rtl/up_bus_arb_pkg.sv | 21 ++
 rtl/up_bus_arb_channel.sv | 125 ++++++++++++
 rtl/up_bus_arbiter.sv | 99 +++++++++
 tb/tb_up_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_bus_arb_pkg.sv
// Shared definitions for the up bus arbiter: channel FSM encoding, defaults and
// the two-master round-robin pick.
package up_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_DEAD;

    // On a tie the master that did not win last time gets the bus.
    function automatic logic rr_pick(input logic [1:0] cand, input logic last_grant);
        if (cand == 2'b11) begin
            return ~last_grant;
        end
        return cand[1];
    endfunction

endpackage

// File: rtl/up_bus_arb_channel.sv
// One arbitrated up bus channel: two pending request slots, round-robin grant,
// single-cycle slave request and a timeout that forces completion.
module up_bus_arb_channel
    import up_bus_arb_pkg::*;
#(
    parameter int          PAY_WIDTH      = 14,
    parameter bit          HAS_RDATA      = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_req_i,
    input  logic [2*PAY_WIDTH-1:0] m_pay_i,
    output logic [1:0]             m_ack_o,
    output logic [63:0]            m_rdata_o,
    output logic                   s_req_o,
    output logic [PAY_WIDTH-1:0]   s_pay_o,
    input  logic                   s_ack_i,
    input  logic [31:0]            s_rdata_i,
    output logic                   timeout_o
);

    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [1:0]           pend_q, pend_d;
    logic [PAY_WIDTH-1:0] slot_q [2];
    logic [PAY_WIDTH-1:0] slot_d [2];
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 done;
    logic                 expired;

    // A pulse only lands in a free slot; the owner's slot stays pending until completion.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | m_req_i;
        slot_d  = slot_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        rdata_d = '0;
        done    = 1'b0;
        expired = 1'b0;

        for (int i = 0; i < 2; i++) begin
            if (m_req_i[i] && !pend_q[i]) begin
                slot_d[i] = m_pay_i[i*PAY_WIDTH +: PAY_WIDTH];
            end
        end

        unique case (state_q)
            IDLE: begin
                if ((pend_q | m_req_i) != 2'b00) begin
                    grant_d = rr_pick(pend_q | m_req_i, last_q);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
                done    = s_ack_i;
            end
            WAIT: begin
                cnt_d   = cnt_q + CW'(1);
                done    = s_ack_i;
                expired = TO_EN && !s_ack_i && (cnt_q == CNT_LAST);
            end
            default: state_d = IDLE;
        endcase

        if (done || expired) begin
            state_d          = IDLE;
            ack_d[grant_q]   = 1'b1;
            pend_d[grant_q]  = 1'b0;
            last_d           = grant_q;
            rdata_d          = !HAS_RDATA ? 32'h0 : (expired ? TIMEOUT_RDATA : s_rdata_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            slot_q    <= slot_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        m_rdata_o = '0;
        for (int i = 0; i < 2; i++) begin
            if (ack_q[i]) begin
                m_rdata_o[i*32 +: 32] = rdata_q;
            end
        end
    end

    assign m_ack_o   = ack_q;
    assign s_req_o   = (state_q == ISSUE);
    assign s_pay_o   = (state_q == IDLE) ? '0 : slot_q[grant_q];
    assign timeout_o = expired;

endmodule

// File: rtl/up_bus_arbiter.sv
// Two-master arbiter for the up register bus: independent write and read
// channels plus sticky timeout status.
module up_bus_arbiter
    import up_bus_arb_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 14,
    parameter int          TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT
) (
    input  logic                       up_clk,
    input  logic                       up_rst,
    input  logic [1:0]                 m_wreq,
    input  logic [2*ADDRESS_WIDTH-1:0] m_waddr,
    input  logic [63:0]                m_wdata,
    output logic [1:0]                 m_wack,
    input  logic [1:0]                 m_rreq,
    input  logic [2*ADDRESS_WIDTH-1:0] m_raddr,
    output logic [63:0]                m_rdata,
    output logic [1:0]                 m_rack,
    output logic                       s_wreq,
    output logic [ADDRESS_WIDTH-1:0]   s_waddr,
    output logic [31:0]                s_wdata,
    input  logic                       s_wack,
    output logic                       s_rreq,
    output logic [ADDRESS_WIDTH-1:0]   s_raddr,
    input  logic [31:0]                s_rdata,
    input  logic                       s_rack,
    output logic [1:0]                 up_timeout_status,
    input  logic                       up_timeout_clr
);

    localparam int AW  = ADDRESS_WIDTH;
    localparam int WPW = ADDRESS_WIDTH + 32;

    logic [2*WPW-1:0] wr_pay;
    logic [WPW-1:0]   wr_slave_pay;
    logic [63:0]      unused_wr_rdata;
    logic             wr_expired;
    logic             rd_expired;
    logic [1:0]       status_q, status_d;

    // Each write slot carries {address, data} so one channel module serves both directions.
    assign wr_pay               = {m_waddr[AW +: AW], m_wdata[63:32], m_waddr[AW-1:0], m_wdata[31:0]};
    assign {s_waddr, s_wdata}   = wr_slave_pay;

    up_bus_arb_channel #(
        .PAY_WIDTH      (WPW),
        .HAS_RDATA      (1'b0),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_RDATA  (TIMEOUT_RDATA)
    ) u_wr_channel (
        .clk_i     (up_clk),
        .rst_i     (up_rst),
        .m_req_i   (m_wreq),
        .m_pay_i   (wr_pay),
        .m_ack_o   (m_wack),
        .m_rdata_o (unused_wr_rdata),
        .s_req_o   (s_wreq),
        .s_pay_o   (wr_slave_pay),
        .s_ack_i   (s_wack),
        .s_rdata_i (32'h0),
        .timeout_o (wr_expired)
    );

    up_bus_arb_channel #(
        .PAY_WIDTH      (AW),
        .HAS_RDATA      (1'b1),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_RDATA  (TIMEOUT_RDATA)
    ) u_rd_channel (
        .clk_i     (up_clk),
        .rst_i     (up_rst),
        .m_req_i   (m_rreq),
        .m_pay_i   (m_raddr),
        .m_ack_o   (m_rack),
        .m_rdata_o (m_rdata),
        .s_req_o   (s_rreq),
        .s_pay_o   (s_raddr),
        .s_ack_i   (s_rack),
        .s_rdata_i (s_rdata),
        .timeout_o (rd_expired)
    );

    // Clear wins over a timeout landing in the same cycle.
    always_comb begin
        status_d = up_timeout_clr ? 2'b00 : (status_q | {rd_expired, wr_expired});
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            status_q <= 2'b00;
        end else begin
            status_q <= status_d;
        end
    end

    assign up_timeout_status = status_q;

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Self-checking bench for up_bus_arbiter: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_up_bus_arbiter;

    localparam int          AW      = 14;
    localparam int          TO      = 4;
    localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

    logic            up_clk = 1'b0;
    logic            up_rst;
    logic [1:0]      m_wreq, m_rreq, m_wack, m_rack;
    logic [2*AW-1:0] m_waddr, m_raddr;
    logic [63:0]     m_wdata, m_rdata;
    logic            s_wreq, s_rreq, s_wack, s_rack;
    logic [AW-1:0]   s_waddr, s_raddr;
    logic [31:0]     s_wdata, s_rdata;
    logic [1:0]      up_timeout_status;
    logic            up_timeout_clr;

    int checks = 0;
    int passes = 0;
    bit modelOn = 1'b0;

    always #5 up_clk = ~up_clk;

    up_bus_arbiter #(
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_RDATA  (TO_DATA)
    ) dut (
        .up_clk            (up_clk),
        .up_rst            (up_rst),
        .m_wreq            (m_wreq),
        .m_waddr           (m_waddr),
        .m_wdata           (m_wdata),
        .m_wack            (m_wack),
        .m_rreq            (m_rreq),
        .m_raddr           (m_raddr),
        .m_rdata           (m_rdata),
        .m_rack            (m_rack),
        .s_wreq            (s_wreq),
        .s_waddr           (s_waddr),
        .s_wdata           (s_wdata),
        .s_wack            (s_wack),
        .s_rreq            (s_rreq),
        .s_raddr           (s_raddr),
        .s_rdata           (s_rdata),
        .s_rack            (s_rack),
        .up_timeout_status (up_timeout_status),
        .up_timeout_clr    (up_timeout_clr)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to the next cycle and drive this cycle's pulses; addresses are set by the caller.
    task automatic applyStimulus(input logic [1:0] wreq, input logic [1:0] rreq,
                                 input logic wack, input logic rack, input logic [31:0] rdata);
        @(posedge up_clk);
        #1;
        m_wreq         = wreq;
        m_rreq         = rreq;
        s_wack         = wack;
        s_rack         = rack;
        s_rdata        = rdata;
        up_timeout_clr = 1'b0;
    endtask

    task automatic resetDut();
        @(posedge up_clk);
        #1;
        up_rst = 1'b1;
        m_wreq = '0; m_rreq = '0; s_wack = 1'b0; s_rack = 1'b0; up_timeout_clr = 1'b0;
        repeat (2) @(posedge up_clk);
        #1;
        up_rst = 1'b0;
    endtask

    // Transaction-level reference: channel 0 = write, 1 = read. A busy channel
    // tracks its owner and how many cycles have passed since the slave request.
    bit             mdlBusy    [2];
    bit             mdlOwner   [2];
    int             mdlAge     [2];
    bit             mdlLastWin [2];
    bit [1:0]       mdlPend    [2];
    logic [AW+31:0] mdlSlot    [2][2];
    bit [1:0]       mdlAck     [2];
    logic [31:0]    mdlData    [2];
    bit [1:0]       mdlStatus;

    initial begin : modelProc
        bit [1:0]       req;
        bit [1:0]       cand;
        bit             ack;
        bit             finished;
        bit             timedOut;
        bit [1:0]       expiredBits;
        logic [AW+31:0] pay [2];
        forever begin
            @(posedge up_clk);
            if (up_rst) begin
                for (int c = 0; c < 2; c++) begin
                    mdlBusy[c] = 0; mdlOwner[c] = 0; mdlAge[c] = 0; mdlLastWin[c] = 1;
                    mdlPend[c] = 0; mdlAck[c] = 0; mdlData[c] = 0;
                    mdlSlot[c][0] = '0; mdlSlot[c][1] = '0;
                end
                mdlStatus = 0;
            end else begin
                expiredBits = 0;
                for (int c = 0; c < 2; c++) begin
                    req = (c == 0) ? m_wreq : m_rreq;
                    ack = (c == 0) ? s_wack : s_rack;
                    for (int i = 0; i < 2; i++) begin
                        pay[i] = (c == 0) ? {m_waddr[i*AW +: AW], m_wdata[i*32 +: 32]}
                                          : {m_raddr[i*AW +: AW], 32'h0};
                    end
                    finished = 0;
                    timedOut = 0;
                    mdlAck[c]  = 0;
                    mdlData[c] = 0;
                    if (mdlBusy[c]) begin
                        if (ack) begin
                            finished = 1;
                        end else if (TO != 0 && mdlAge[c] == TO) begin
                            finished = 1;
                            timedOut = 1;
                        end else begin
                            mdlAge[c] = mdlAge[c] + 1;
                        end
                    end else begin
                        cand = mdlPend[c] | req;
                        if (cand != 2'b00) begin
                            if (cand == 2'b11) mdlOwner[c] = (mdlLastWin[c] == 1) ? 0 : 1;
                            else               mdlOwner[c] = (cand == 2'b01) ? 0 : 1;
                            mdlBusy[c] = 1;
                            mdlAge[c]  = 0;
                        end
                    end
                    for (int i = 0; i < 2; i++) begin
                        if (req[i] && !mdlPend[c][i]) begin
                            mdlPend[c][i] = 1;
                            mdlSlot[c][i] = pay[i];
                        end
                    end
                    if (finished) begin
                        mdlBusy[c] = 0;
                        mdlPend[c][mdlOwner[c]] = 0;
                        mdlLastWin[c] = mdlOwner[c];
                        mdlAck[c][mdlOwner[c]] = 1;
                        if (c == 1) mdlData[c] = timedOut ? TO_DATA : s_rdata;
                        if (timedOut) expiredBits[c] = 1;
                    end
                end
                mdlStatus = up_timeout_clr ? 2'b00 : (mdlStatus | {expiredBits[1], expiredBits[0]});
            end
        end
    end

    initial begin : compareProc
        logic [63:0] expRdata;
        forever begin
            @(negedge up_clk);
            if (modelOn) begin
                expRdata = '0;
                for (int i = 0; i < 2; i++) begin
                    if (mdlAck[1][i]) expRdata[i*32 +: 32] = mdlData[1];
                end
                checkOutput("m_wack", 64'(m_wack), 64'(mdlAck[0]));
                checkOutput("m_rack", 64'(m_rack), 64'(mdlAck[1]));
                checkOutput("m_rdata", m_rdata, expRdata);
                checkOutput("s_wreq", 64'(s_wreq), 64'(mdlBusy[0] && mdlAge[0] == 0));
                checkOutput("s_rreq", 64'(s_rreq), 64'(mdlBusy[1] && mdlAge[1] == 0));
                if (mdlBusy[0]) checkOutput("s_wpayload", 64'({s_waddr, s_wdata}), 64'(mdlSlot[0][mdlOwner[0]]));
                if (mdlBusy[1]) checkOutput("s_raddr", 64'(s_raddr), 64'(mdlSlot[1][mdlOwner[1]][AW+31:32]));
                checkOutput("timeout_status", 64'(up_timeout_status), 64'(mdlStatus));
            end
        end
    end

    initial begin : stimProc
        int acks;
        up_rst = 1'b1;
        m_wreq = '0; m_rreq = '0; m_waddr = '0; m_raddr = '0; m_wdata = '0;
        s_wack = 1'b0; s_rack = 1'b0; s_rdata = '0; up_timeout_clr = 1'b0;
        @(posedge up_clk);
        modelOn = 1'b1;
        resetDut();

        @(negedge up_clk);
        checkOutput("reset_ctrl", 64'({m_wack, m_rack, s_wreq, s_rreq, s_waddr, s_raddr, up_timeout_status}), 64'h0);
        checkOutput("reset_mrdata", m_rdata, 64'h0);
        checkOutput("reset_swdata", 64'(s_wdata), 64'h0);

        $display("[TB] single write");
        m_waddr = {14'h0, 14'h0010};
        m_wdata = {32'h0, 32'h1234_5678};
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("wr_issue", 64'({s_wreq, s_waddr, s_wdata}), 64'({1'b1, 14'h0010, 32'h1234_5678}));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("wr_ack", 64'(m_wack), 64'h1);

        $display("[TB] simultaneous reads");
        m_raddr = {14'h0002, 14'h0001};
        applyStimulus(2'b00, 2'b11, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'hA);
        @(negedge up_clk);
        checkOutput("rd_issue_m0", 64'({s_rreq, s_raddr}), 64'({1'b1, 14'h0001}));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("rd_ack_m0", 64'(m_rack), 64'h1);
        checkOutput("rd_data_m0", m_rdata, 64'h0000_0000_0000_000A);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'hB);
        @(negedge up_clk);
        checkOutput("rd_issue_m1", 64'({s_rreq, s_raddr}), 64'({1'b1, 14'h0002}));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("rd_ack_m1", 64'(m_rack), 64'h2);
        checkOutput("rd_data_m1", m_rdata, 64'h0000_000B_0000_0000);

        $display("[TB] read timeout");
        m_raddr = {14'h0, 14'h0123};
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0, 32'h0);
        repeat (5) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("to_ack", 64'(m_rack), 64'h1);
        checkOutput("to_data", m_rdata, 64'h0000_0000_DEAD_DEAD);
        checkOutput("to_status", 64'(up_timeout_status), 64'h2);
        repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("to_status_sticky", 64'(up_timeout_status), 64'h2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        up_timeout_clr = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("to_status_clr", 64'(up_timeout_status), 64'h0);

        $display("[TB] concurrent channels");
        m_waddr = {14'h0, 14'h0100};
        m_wdata = {32'h0, 32'hCAFE_0001};
        m_raddr = {14'h0200, 14'h0};
        applyStimulus(2'b01, 2'b10, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 32'h55);
        @(negedge up_clk);
        checkOutput("both_issue", 64'({s_wreq, s_rreq}), 64'h3);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("both_ack", 64'({m_wack, m_rack}), 64'({2'b01, 2'b10}));
        checkOutput("both_rdata", m_rdata, 64'h0000_0055_0000_0000);

        $display("[TB] write fairness");
        resetDut();
        m_waddr = {14'h0222, 14'h0111};
        acks = 0;
        for (int cyc = 0; cyc < 40 && acks < 8; cyc++) begin
            applyStimulus(2'b11, 2'b00, 1'b1, 1'b0, 32'h0);
            @(negedge up_clk);
            if (m_wack != 2'b00) begin
                checkOutput($sformatf("fair_order_%0d", acks), 64'(m_wack), (acks % 2 == 0) ? 64'h1 : 64'h2);
                acks++;
            end
        end
        checkOutput("fair_count", 64'(acks), 64'd8);

        $display("[TB] reset during wait");
        resetDut();
        m_waddr = {14'h0, 14'h00AA};
        m_wdata = {32'h0, 32'h0BAD_F00D};
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        up_rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("rst_mid_ctrl", 64'({m_wack, m_rack, s_wreq, s_rreq, s_waddr, up_timeout_status}), 64'h0);
        checkOutput("rst_mid_wdata", 64'(s_wdata), 64'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        up_rst = 1'b0;
        @(negedge up_clk);
        checkOutput("rst_no_ack", 64'(m_wack), 64'h0);
        m_waddr = {14'h0033, 14'h0};
        m_wdata = {32'h7777_0000, 32'h0};
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("rst_fresh_issue", 64'({s_wreq, s_waddr, s_wdata}), 64'({1'b1, 14'h0033, 32'h7777_0000}));
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        @(negedge up_clk);
        checkOutput("rst_fresh_ack", 64'(m_wack), 64'h2);

        $display("[TB] randomized traffic");
        resetDut();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge up_clk);
            #1;
            up_rst         = ($urandom_range(0, 399) == 0);
            m_wreq         = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            m_rreq         = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            m_waddr        = 28'($urandom);
            m_raddr        = 28'($urandom);
            m_wdata        = {$urandom, $urandom};
            s_wack         = ($urandom_range(0, 2) == 0);
            s_rack         = ($urandom_range(0, 2) == 0);
            s_rdata        = $urandom;
            up_timeout_clr = ($urandom_range(0, 39) == 0);
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
        up_rst = 1'b0;
        repeat (2) @(posedge up_clk);
        @(negedge up_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
